counter_mod: RTL

Parametrised successor to the fixed 7-bit free-running counter. Adds:
- configurable width and modulus
- up/down counting
- enable, synchronous clear and parallel load
- wrap or saturate mode
- terminal-count, wrap and sticky overflow status

Used as the general event/timebase counter in datapath and timer blocks.

---
 rtl/counter_mod.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/counter_mod.sv
//==============================================================================
// Module      : counter_mod
// Description : General-purpose event/timebase counter. Counts 0..MAX_VAL up
//               or down. Each edge does at most one of: clear, parallel load
//               (clamped to MAX_VAL), or one count step. At the limits it
//               either wraps or saturates. Status outputs are a lookahead
//               terminal count, a one-cycle wrap pulse and a sticky
//               limit-hit flag.
// Revision    : 1.0 - initial parametrised release
//------------------------------------------------------------------------------
// Parameters:
//   WIDTH     - counter width in bits (>= 2)
//   MAX_VAL   - highest count value (<= 2**WIDTH-1)
//   SATURATE  - 0: wrap at the limits, 1: hold at the limits
//   RESET_VAL - value of Q after reset or clear (<= MAX_VAL)
// Ports:
//   CLK      in   1      clock, all state changes on the rising edge
//   Reset_n  in   1      synchronous active-low reset
//   En       in   1      count enable
//   Up       in   1      direction, 1 = increment, 0 = decrement
//   Clr      in   1      synchronous clear to RESET_VAL
//   Load     in   1      synchronous parallel load of D
//   D        in   WIDTH  load value
//   Q        out  WIDTH  current count (registered)
//   TC       out  1      terminal count (combinational lookahead)
//   Wrap     out  1      registered one-cycle wrap pulse
//   Ovf      out  1      sticky limit-hit flag (registered)
//==============================================================================
`default_nettype none

module counter_mod #(
  parameter int WIDTH     = 7,
  parameter int MAX_VAL   = (2 ** WIDTH) - 1,
  parameter int SATURATE  = 0,
  parameter int RESET_VAL = 0
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             En,
  input  logic             Up,
  input  logic             Clr,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             Wrap,
  output logic             Ovf
);

  // Parameter values narrowed once so that every comparison below is done
  // at WIDTH bits.
  localparam logic [WIDTH-1:0] c_MAX     = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] c_RST_VAL = WIDTH'(RESET_VAL);
  localparam logic             c_SAT     = (SATURATE != 0);

  // Elaboration-time sanity checks on the parameter set.
  if (WIDTH < 2) begin : g_chk_width
    $error("counter_mod: WIDTH must be >= 2");
  end
  if ((MAX_VAL < 1) || (MAX_VAL > (2 ** WIDTH) - 1)) begin : g_chk_max
    $error("counter_mod: MAX_VAL must lie in 1..2**WIDTH-1");
  end
  if ((RESET_VAL < 0) || (RESET_VAL > MAX_VAL)) begin : g_chk_rst
    $error("counter_mod: RESET_VAL must lie in 0..MAX_VAL");
  end

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             ovf_q;
  logic             ovf_d;

  logic             w_at_max;
  logic             w_at_min;
  logic [WIDTH-1:0] w_load_val;

  assign w_at_max = (q_q == c_MAX);
  assign w_at_min = (q_q == '0);

  // A load above MAX_VAL is the only way to reach an out-of-range value,
  // so clamping here keeps Q inside 0..MAX_VAL at all times.
  assign w_load_val = (D > c_MAX) ? c_MAX : D;

  //--------------------------------------------------------------------------
  // Next-state logic. Priority: Clr > Load > En. Wrap defaults low so it is
  // only ever a single-cycle pulse.
  //--------------------------------------------------------------------------
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;

    if (Clr) begin
      q_d   = c_RST_VAL;
      ovf_d = 1'b0;
    end else if (Load) begin
      q_d = w_load_val;
    end else if (En) begin
      if (Up) begin
        if (w_at_max) begin
          ovf_d = 1'b1;
          if (!c_SAT) begin
            q_d    = '0;
            wrap_d = 1'b1;
          end
        end else begin
          q_d = q_q + 1'b1;
        end
      end else begin
        if (w_at_min) begin
          ovf_d = 1'b1;
          if (!c_SAT) begin
            q_d    = c_MAX;
            wrap_d = 1'b1;
          end
        end else begin
          q_d = q_q - 1'b1;
        end
      end
    end
  end

  //--------------------------------------------------------------------------
  // State registers with synchronous active-low reset.
  //--------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      q_q    <= c_RST_VAL;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  // TC looks ahead: it is high in the cycle before the edge that would cross
  // a limit, using the live En/Up. It is deliberately not gated by
  // Clr/Load/Reset_n.
  assign TC   = En & ((Up & w_at_max) | (~Up & w_at_min));
  assign Q    = q_q;
  assign Wrap = wrap_q;
  assign Ovf  = ovf_q;

endmodule

`default_nettype wire
